// File: rtl/axil_mem_bist_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface AXI_LITE #(
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 32
);
   logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
   logic [2:0]                  aw_prot;
   logic                        aw_valid;
   logic                        aw_ready;
   logic [AXI_DATA_WIDTH-1:0]   w_data;
   logic [AXI_DATA_WIDTH/8-1:0] w_strb;
   logic                        w_valid;
   logic                        w_ready;
   logic [1:0]                  b_resp;
   logic                        b_valid;
   logic                        b_ready;
   logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
   logic [2:0]                  ar_prot;
   logic                        ar_valid;
   logic                        ar_ready;
   logic [AXI_DATA_WIDTH-1:0]   r_data;
   logic [1:0]                  r_resp;
   logic                        r_valid;
   logic                        r_ready;

   modport Master (
      output aw_addr, aw_prot, aw_valid, input aw_ready,
      output w_data, w_strb, w_valid, input w_ready,
      input b_resp, b_valid, output b_ready,
      output ar_addr, ar_prot, ar_valid, input ar_ready,
      input r_data, r_resp, r_valid, output r_ready
   );

   modport Slave (
      input aw_addr, aw_prot, aw_valid, output aw_ready,
      input w_data, w_strb, w_valid, output w_ready,
      output b_resp, b_valid, input b_ready,
      input ar_addr, ar_prot, ar_valid, output ar_ready,
      output r_data, r_resp, r_valid, input r_ready
   );
endinterface

// File: rtl/axil_mem_bist.sv
// Memory BIST over AXI4-Lite: writes PATTERN^i to every word, then reads back
// and compares, counting errors and latching the first failing address.
module axil_mem_bist #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter logic [31:0] MEMORY_SIZE = 32'h0002_0000,
   parameter logic [31:0] PATTERN     = 32'hA5A5_5A5A
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic [15:0] err_cnt_o,
   output logic [31:0] fail_addr_o,
   AXI_LITE.Master     master
);
   localparam logic [31:0] WORDS = MEMORY_SIZE >> 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t      state_r;
   logic [31:0] idx_r;
   logic        busy_r, done_r, pass_r;
   logic [15:0] err_cnt_r;
   logic [31:0] fail_addr_r;
   logic        aw_valid_r, w_valid_r, b_ready_r, ar_valid_r, r_ready_r;
   logic [31:0] aw_addr_r, w_data_r, ar_addr_r;

   logic        last_s;
   logic        err_now_s;
   logic [31:0] nxt_idx_s, cur_addr_s, nxt_addr_s, exp_data_s;

   assign last_s     = (idx_r == (WORDS - 32'd1));
   assign nxt_idx_s  = idx_r + 32'd1;
   assign cur_addr_s = BASE_ADDR + {idx_r[29:0], 2'b00};
   assign nxt_addr_s = BASE_ADDR + {nxt_idx_s[29:0], 2'b00};
   assign exp_data_s = PATTERN ^ idx_r;

   // Flags a failing beat: non-OKAY response on either channel or read miscompare.
   always_comb begin
      err_now_s = 1'b0;
      case (state_r)
         WR_RESP: begin
            if (master.b_valid && b_ready_r) begin
               err_now_s = (master.b_resp != 2'b00);
            end else begin
               err_now_s = 1'b0;
            end
         end
         RD_RESP: begin
            if (master.r_valid && r_ready_r) begin
               err_now_s = (master.r_resp != 2'b00) || (master.r_data != exp_data_s);
            end else begin
               err_now_s = 1'b0;
            end
         end
         default: err_now_s = 1'b0;
      endcase
   end

   // Test sequencer; every status and AXI output is a register of this block.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r     <= IDLE;
         idx_r       <= 32'd0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         err_cnt_r   <= 16'd0;
         fail_addr_r <= 32'd0;
         aw_valid_r  <= 1'b0;
         w_valid_r   <= 1'b0;
         b_ready_r   <= 1'b0;
         ar_valid_r  <= 1'b0;
         r_ready_r   <= 1'b0;
         aw_addr_r   <= 32'd0;
         w_data_r    <= 32'd0;
         ar_addr_r   <= 32'd0;
      end else begin
         if (err_now_s) begin
            if (err_cnt_r != 16'hFFFF) begin
               err_cnt_r <= err_cnt_r + 16'd1;
            end
            if (err_cnt_r == 16'd0) begin
               fail_addr_r <= cur_addr_s;
            end
         end
         case (state_r)
            IDLE, DONE: begin
               if (start_i) begin
                  state_r     <= WR_REQ;
                  idx_r       <= 32'd0;
                  busy_r      <= 1'b1;
                  done_r      <= 1'b0;
                  pass_r      <= 1'b0;
                  err_cnt_r   <= 16'd0;
                  fail_addr_r <= 32'd0;
                  aw_valid_r  <= 1'b1;
                  w_valid_r   <= 1'b1;
                  aw_addr_r   <= BASE_ADDR;
                  w_data_r    <= PATTERN;
               end
            end
            WR_REQ: begin
               // Each channel drops on its own handshake; leave once both are done.
               if (master.aw_ready) begin
                  aw_valid_r <= 1'b0;
               end
               if (master.w_ready) begin
                  w_valid_r <= 1'b0;
               end
               if ((!aw_valid_r || master.aw_ready) && (!w_valid_r || master.w_ready)) begin
                  state_r   <= WR_RESP;
                  b_ready_r <= 1'b1;
               end
            end
            WR_RESP: begin
               if (master.b_valid) begin
                  b_ready_r <= 1'b0;
                  if (last_s) begin
                     idx_r      <= 32'd0;
                     state_r    <= RD_REQ;
                     ar_valid_r <= 1'b1;
                     ar_addr_r  <= BASE_ADDR;
                  end else begin
                     idx_r      <= nxt_idx_s;
                     state_r    <= WR_REQ;
                     aw_valid_r <= 1'b1;
                     w_valid_r  <= 1'b1;
                     aw_addr_r  <= nxt_addr_s;
                     w_data_r   <= PATTERN ^ nxt_idx_s;
                  end
               end
            end
            RD_REQ: begin
               if (master.ar_ready) begin
                  ar_valid_r <= 1'b0;
                  r_ready_r  <= 1'b1;
                  state_r    <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (master.r_valid) begin
                  r_ready_r <= 1'b0;
                  if (last_s) begin
                     state_r <= DONE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     pass_r  <= (err_cnt_r == 16'd0) && !err_now_s;
                  end else begin
                     idx_r      <= nxt_idx_s;
                     state_r    <= RD_REQ;
                     ar_valid_r <= 1'b1;
                     ar_addr_r  <= nxt_addr_s;
                  end
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign busy_o      = busy_r;
   assign done_o      = done_r;
   assign pass_o      = pass_r;
   assign err_cnt_o   = err_cnt_r;
   assign fail_addr_o = fail_addr_r;

   assign master.aw_addr  = aw_addr_r;
   assign master.aw_prot  = 3'b000;
   assign master.aw_valid = aw_valid_r;
   assign master.w_data   = w_data_r;
   assign master.w_strb   = 4'hF;
   assign master.w_valid  = w_valid_r;
   assign master.b_ready  = b_ready_r;
   assign master.ar_addr  = ar_addr_r;
   assign master.ar_prot  = 3'b000;
   assign master.ar_valid = ar_valid_r;
   assign master.r_ready  = r_ready_r;
endmodule

// File: tb/tb_axil_mem_bist.sv
// Bench for axil_mem_bist: configurable RAM slave, table vectors, random runs
// against a word-level outcome model, plus reset/restart and single-word cases.
module tb_axil_mem_bist;
   localparam logic [31:0] PAT = 32'hA5A5_5A5A;
   localparam int NW = 16;

   logic clk = 1'b0;
   logic rst_n, start, start1;
   logic busy, done, pass, busy1, done1, pass1;
   logic [15:0] err_cnt, err1;
   logic [31:0] fail_addr, fail1;
   int n_checks = 0;
   int n_pass = 0;

   AXI_LITE bus ();
   AXI_LITE bus1 ();

   always #5 clk = ~clk;

   axil_mem_bist #(.BASE_ADDR(32'h0), .MEMORY_SIZE(32'h40), .PATTERN(PAT)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
      .pass_o(pass), .err_cnt_o(err_cnt), .fail_addr_o(fail_addr), .master(bus));

   axil_mem_bist #(.BASE_ADDR(32'h0000_1000), .MEMORY_SIZE(32'h4), .PATTERN(PAT)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .busy_o(busy1), .done_o(done1),
      .pass_o(pass1), .err_cnt_o(err1), .fail_addr_o(fail1), .master(bus1));

   typedef struct {
      logic        stuck_en;
      logic [31:0] stuck_addr;
      int          stuck_bit;
      logic        stuck_val;
      logic [15:0] bad_b;
      logic [15:0] bad_r;
      int          aw_dly;
      int          w_dly;
      int          ar_dly;
      int          exp_werr;
      int          exp_err;
      logic [31:0] exp_fail;
      logic        exp_pass;
   } vec_t;

   // ---------------- RAM slave for the 16-word DUT ----------------
   logic        stuck_en = 1'b0;
   logic [31:0] stuck_addr = 32'h0;
   int          stuck_bit = 0;
   logic        stuck_val = 1'b0;
   logic [15:0] bad_b = 16'h0, bad_r = 16'h0;
   int          aw_dly = 0, w_dly = 0, ar_dly = 0;

   logic [31:0] mem [NW];
   int          aw_wait = 0, w_wait = 0, ar_wait = 0;
   logic        aw_got = 1'b0, w_got = 1'b0, b_v = 1'b0, r_v = 1'b0;
   logic [31:0] wa = 32'h0, wd = 32'h0, r_d = 32'h0;
   logic [1:0]  b_r = 2'b00, r_rs = 2'b00;
   int          aw_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
   logic        aw_hs, w_hs, ar_hs;
   logic [31:0] waddr_s, wdata_s;

   assign bus.aw_ready = bus.aw_valid && (aw_wait >= aw_dly);
   assign bus.w_ready  = bus.w_valid && (w_wait >= w_dly);
   assign bus.ar_ready = bus.ar_valid && (ar_wait >= ar_dly);
   assign bus.b_valid  = b_v;
   assign bus.b_resp   = b_r;
   assign bus.r_valid  = r_v;
   assign bus.r_data   = r_d;
   assign bus.r_resp   = r_rs;
   assign aw_hs   = bus.aw_valid && bus.aw_ready;
   assign w_hs    = bus.w_valid && bus.w_ready;
   assign ar_hs   = bus.ar_valid && bus.ar_ready;
   assign waddr_s = aw_hs ? bus.aw_addr : wa;
   assign wdata_s = w_hs ? bus.w_data : wd;

   function automatic logic [31:0] stored(input logic [31:0] addr, input logic [31:0] d);
      logic [31:0] v = d;
      if (stuck_en && addr == stuck_addr) v[stuck_bit] = stuck_val;
      return v;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; b_v <= 1'b0; r_v <= 1'b0;
      end else begin
         aw_wait <= (bus.aw_valid && !aw_hs) ? aw_wait + 1 : 0;
         w_wait  <= (bus.w_valid && !w_hs) ? w_wait + 1 : 0;
         ar_wait <= (bus.ar_valid && !ar_hs) ? ar_wait + 1 : 0;
         if (aw_hs) begin aw_got <= 1'b1; wa <= bus.aw_addr; aw_cnt <= aw_cnt + 1; end
         if (w_hs) begin w_got <= 1'b1; wd <= bus.w_data; end
         if ((aw_got || aw_hs) && (w_got || w_hs) && !b_v) begin
            mem[waddr_s[5:2]] <= stored(waddr_s, wdata_s);
            b_v <= 1'b1;
            b_r <= bad_b[waddr_s[5:2]] ? 2'b10 : 2'b00;
            aw_got <= 1'b0;
            w_got <= 1'b0;
         end
         if (b_v && bus.b_ready) begin b_v <= 1'b0; b_cnt <= b_cnt + 1; end
         if (ar_hs) begin
            r_v <= 1'b1;
            r_d <= mem[bus.ar_addr[5:2]];
            r_rs <= bad_r[bus.ar_addr[5:2]] ? 2'b10 : 2'b00;
            ar_cnt <= ar_cnt + 1;
         end
         if (r_v && bus.r_ready) begin r_v <= 1'b0; r_cnt <= r_cnt + 1; end
      end
   end

   // Protocol monitor: valid/payload stability, single outstanding transaction.
   logic        pv_aw = 1'b0, pv_w = 1'b0, pv_ar = 1'b0, ar_prev = 1'b0;
   logic [31:0] pa_aw = 32'h0, pd_w = 32'h0, pa_ar = 32'h0;
   int          viol = 0;
   int          wph_err = -1;
   always @(posedge clk) begin
      if (rst_n) begin
         if ((pv_aw && (!bus.aw_valid || bus.aw_addr != pa_aw)) ||
             (pv_w && (!bus.w_valid || bus.w_data != pd_w)) ||
             (pv_ar && (!bus.ar_valid || bus.ar_addr != pa_ar)) ||
             ((bus.aw_valid || bus.ar_valid) && (b_v || r_v)))
            viol <= viol + 1;
         if (bus.ar_valid && !ar_prev && bus.ar_addr == 32'h0) wph_err <= int'(err_cnt);
      end
      pv_aw <= rst_n && bus.aw_valid && !aw_hs;
      pv_w  <= rst_n && bus.w_valid && !w_hs;
      pv_ar <= rst_n && bus.ar_valid && !ar_hs;
      pa_aw <= bus.aw_addr;
      pd_w  <= bus.w_data;
      pa_ar <= bus.ar_addr;
      ar_prev <= bus.ar_valid;
   end

   // ---------------- always-ready slave for the single-word DUT ----------------
   logic [31:0] m1 = 32'h0, a1 = 32'h0, ra1 = 32'h0;
   logic        b1v = 1'b0, r1v = 1'b0;
   int          aw1_cnt = 0, ar1_cnt = 0;
   assign bus1.aw_ready = 1'b1;
   assign bus1.w_ready  = 1'b1;
   assign bus1.ar_ready = 1'b1;
   assign bus1.b_valid  = b1v;
   assign bus1.b_resp   = 2'b00;
   assign bus1.r_valid  = r1v;
   assign bus1.r_data   = m1;
   assign bus1.r_resp   = 2'b00;
   always @(posedge clk) begin
      if (!rst_n) begin
         b1v <= 1'b0; r1v <= 1'b0;
      end else begin
         if (bus1.aw_valid && bus1.w_valid) begin
            a1 <= bus1.aw_addr; m1 <= bus1.w_data; b1v <= 1'b1; aw1_cnt <= aw1_cnt + 1;
         end
         if (b1v && bus1.b_ready) b1v <= 1'b0;
         if (bus1.ar_valid) begin ra1 <= bus1.ar_addr; r1v <= 1'b1; ar1_cnt <= ar1_cnt + 1; end
         if (r1v && bus1.r_ready) r1v <= 1'b0;
      end
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Outcome model: one record per word, errors in write-then-read order.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      logic [31:0] want, got;
      r.exp_err = 0;
      r.exp_fail = 32'h0;
      for (int i = 0; i < NW; i++) begin
         if (v.bad_b[i]) begin
            if (r.exp_err == 0) r.exp_fail = 32'(i * 4);
            r.exp_err++;
         end
      end
      r.exp_werr = r.exp_err;
      for (int i = 0; i < NW; i++) begin
         want = PAT ^ 32'(i);
         got = want;
         if (v.stuck_en && v.stuck_addr == 32'(i * 4)) got[v.stuck_bit] = v.stuck_val;
         if (v.bad_r[i] || got != want) begin
            if (r.exp_err == 0) r.exp_fail = 32'(i * 4);
            r.exp_err++;
         end
      end
      r.exp_pass = (r.exp_err == 0);
      return r;
   endfunction

   task automatic apply(input vec_t v, input string tag, input logic noisy);
      int aw0, b0, ar0, r0, vi0, c;
      stuck_en = v.stuck_en; stuck_addr = v.stuck_addr; stuck_bit = v.stuck_bit;
      stuck_val = v.stuck_val; bad_b = v.bad_b; bad_r = v.bad_r;
      aw_dly = v.aw_dly; w_dly = v.w_dly; ar_dly = v.ar_dly;
      aw0 = aw_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt; vi0 = viol;
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, " busy_at_start"}, 32'(busy), 32'd1);
      check({tag, " status_cleared"}, {29'd0, done, pass, |err_cnt}, 32'd0);
      c = 0;
      while (!done && c < 3000) begin
         start = noisy && (c % 29 == 5);
         tick();
         c++;
      end
      start = 1'b0;
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " busy_end"}, 32'(busy), 32'd0);
      check({tag, " pass"}, 32'(pass), 32'(v.exp_pass));
      check({tag, " err_cnt"}, 32'(err_cnt), 32'(v.exp_err));
      check({tag, " fail_addr"}, fail_addr, v.exp_fail);
      check({tag, " write_phase_err"}, 32'(wph_err), 32'(v.exp_werr));
      check({tag, " aw_count"}, 32'(aw_cnt - aw0), 32'd16);
      check({tag, " b_count"}, 32'(b_cnt - b0), 32'd16);
      check({tag, " ar_count"}, 32'(ar_cnt - ar0), 32'd16);
      check({tag, " r_count"}, 32'(r_cnt - r0), 32'd16);
      check({tag, " protocol"}, 32'(viol - vi0), 32'd0);
   endtask

   vec_t vecs [7];
   vec_t rv;
   int   cnt, act, a0, r0;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      start1 = 1'b0;
      //             stuck_en addr      bit val  bad_b     bad_r     awd wd ard werr err fail      pass
      vecs[0] = '{1'b0, 32'h00, 0, 1'b0, 16'h0000, 16'h0000, 0, 0, 0, 0,  0,  32'h00, 1'b1};
      vecs[1] = '{1'b1, 32'h14, 0, 1'b0, 16'h0000, 16'h0000, 0, 0, 0, 0,  1,  32'h14, 1'b0};
      vecs[2] = '{1'b0, 32'h00, 0, 1'b0, 16'hFFFF, 16'h0000, 0, 0, 0, 16, 16, 32'h00, 1'b0};
      vecs[3] = '{1'b0, 32'h00, 0, 1'b0, 16'h0000, 16'h0000, 3, 1, 0, 0,  0,  32'h00, 1'b1};
      vecs[4] = '{1'b0, 32'h00, 0, 1'b0, 16'h0000, 16'h8000, 0, 2, 2, 0,  1,  32'h3C, 1'b0};
      vecs[5] = '{1'b1, 32'h14, 0, 1'b0, 16'h0010, 16'h0000, 1, 0, 1, 1,  2,  32'h10, 1'b0};
      vecs[6] = '{1'b1, 32'h14, 0, 1'b1, 16'h0000, 16'h0000, 0, 0, 0, 0,  0,  32'h00, 1'b1};

      repeat (3) tick();
      check("reset status", {28'd0, busy, done, pass, |err_cnt}, 32'd0);
      check("reset fail_addr", fail_addr, 32'd0);
      check("reset axi valids", {27'd0, bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready}, 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      for (int k = 0; k < 7; k++) begin
         apply(vecs[k], $sformatf("vec%0d", k), 1'b0);
         if (k == 0) check("word3 data", mem[3], 32'hA5A5_5A59);
      end

      for (int k = 0; k < 6; k++) begin
         rv = vecs[0];
         rv.stuck_en = 1'($urandom_range(0, 1));
         rv.stuck_addr = 32'($urandom_range(0, 15)) << 2;
         rv.stuck_bit = int'($urandom_range(0, 31));
         rv.stuck_val = 1'($urandom_range(0, 1));
         rv.bad_b = 16'($urandom & $urandom & $urandom);
         rv.bad_r = 16'($urandom & $urandom & $urandom);
         rv.aw_dly = int'($urandom_range(0, 3));
         rv.w_dly = int'($urandom_range(0, 3));
         rv.ar_dly = int'($urandom_range(0, 3));
         apply(model(rv), $sformatf("rand%0d", k), 1'b0);
      end

      // Reset during read of word 7, after the stuck bit has already been counted.
      stuck_en = 1'b1; stuck_addr = 32'h14; stuck_bit = 0; stuck_val = 1'b0;
      bad_b = 16'h0; bad_r = 16'h0; aw_dly = 0; w_dly = 0; ar_dly = 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      cnt = 0;
      while (!(bus.ar_valid && bus.ar_addr == 32'h1C) && cnt < 3000) begin
         tick();
         cnt++;
      end
      check("reached read word7", 32'(bus.ar_valid && bus.ar_addr == 32'h1C), 32'd1);
      check("err before reset", 32'(err_cnt), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset status", {28'd0, busy, done, pass, |err_cnt}, 32'd0);
      check("async reset fail_addr", fail_addr, 32'd0);
      check("async reset valids", {27'd0, bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready}, 32'd0);
      check("async reset ar_addr", bus.ar_addr, 32'd0);
      check("async reset aw_addr|w_data", bus.aw_addr | bus.w_data, 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      act = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (bus.aw_valid || bus.w_valid || bus.ar_valid || done || busy) act++;
      end
      check("idle after reset", 32'(act), 32'd0);
      apply(vecs[0], "restart", 1'b1);

      // Single-word memory: exactly one write and one read.
      a0 = aw1_cnt; r0 = ar1_cnt;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      cnt = 0;
      while (!done1 && cnt < 200) begin
         tick();
         cnt++;
      end
      check("n1 done", 32'(done1), 32'd1);
      check("n1 pass", 32'(pass1), 32'd1);
      check("n1 err", 32'(err1), 32'd0);
      check("n1 writes", 32'(aw1_cnt - a0), 32'd1);
      check("n1 reads", 32'(ar1_cnt - r0), 32'd1);
      check("n1 wdata", m1, PAT);
      check("n1 aw_addr", a1, 32'h0000_1000);
      check("n1 ar_addr", ra1, 32'h0000_1000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/axil_mem_bist.md
AXIL_MEM_BIST -- requirements
Module: axil_mem_bist

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first word tested.
REQ-002 The block SHALL have parameter MEMORY_SIZE, default 32'h0002_0000, bytes tested; it must be a non-zero multiple of 4.
REQ-003 The block SHALL have parameter PATTERN, default 32'hA5A5_5A5A, base data seed.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start_i, input, 1 bit: single-cycle test request.
REQ-007 The block SHALL have port busy_o, output, 1 bit: high while a test runs.
REQ-008 The block SHALL have port done_o, output, 1 bit: high once a test completes; held until the next accepted start.
REQ-009 The block SHALL have port pass_o, output, 1 bit: valid while done_o is high; 1 means zero errors.
REQ-010 The block SHALL have port err_cnt_o, output, 16 bits: count of errors, saturating.
REQ-011 The block SHALL have port fail_addr_o, output, 32 bits: byte address of the first error.
REQ-012 The block SHALL have port master, an AXI_LITE.Master interface; address and data widths come from the interface, and it drives the RAM slave upstream.

Function
REQ-013 The block SHALL use states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and DONE.
REQ-014 The block SHALL accept start_i only in IDLE or DONE, and ignore it while busy_o is high.
REQ-015 On an accepted start, the block SHALL do all of the following on the next edge:
- clear err_cnt_o, fail_addr_o, done_o and pass_o;
- set the word index i to 0;
- enter WR_REQ with busy_o set.
REQ-016 Word count SHALL be N = MEMORY_SIZE/4; the address of word i SHALL be BASE_ADDR + 4*i; the expected data SHALL be PATTERN XOR i, with i zero-extended to 32 bits.
REQ-017 On entry to WR_REQ, the block SHALL assert aw_valid and w_valid in the same cycle, with w_strb = 4'hF and aw_prot = 3'b000.
REQ-018 Each of aw_valid and w_valid SHALL drop independently on its own handshake; aw_addr and w_data SHALL be held stable until that handshake.
REQ-019 The block SHALL move to WR_RESP once both handshakes have completed, in the same cycle as the last one or in separate cycles.
REQ-020 The block SHALL hold b_ready high only in WR_RESP. On the b handshake:
- if b_resp != 2'b00, record an error;
- if i == N-1, set i = 0 and go to RD_REQ;
- otherwise increment i and return to WR_REQ.
REQ-021 In RD_REQ, the block SHALL assert ar_valid with ar_addr for word i, and move to RD_RESP on the ar handshake.
REQ-022 The block SHALL hold r_ready high only in RD_RESP. On the r handshake:
- if r_resp != 2'b00 or r_data != expected, record an error;
- if i == N-1, go to DONE;
- otherwise increment i and return to RD_REQ.
REQ-023 Recording an error SHALL increment err_cnt_o, saturating at 16'hFFFF; if err_cnt_o was 0, fail_addr_o SHALL capture the current word address.
REQ-024 The block SHALL have at most one outstanding transaction; no ar or aw is issued before the previous response is accepted.
REQ-025 On entering DONE, the block SHALL do all of the following:
- clear busy_o;
- set done_o;
- set pass_o = (err_cnt_o == 0), counting any error recorded on the final beat.
REQ-026 When N == 1, each phase SHALL issue exactly one transaction.
REQ-027 Any valid signal SHALL stay asserted until its handshake, regardless of the ready timing of the slave.

Reset
REQ-028 While rst_ni is low, the block SHALL immediately force the following, independent of clk_i:
- state = IDLE, i = 0;
- busy_o, done_o and pass_o = 0;
- err_cnt_o = 0 and fail_addr_o = 0;
- all AXI valid and ready outputs = 0, and all AXI address and data outputs = 0.
REQ-029 When reset is asserted mid-test, the block SHALL abandon the test and return to IDLE, with no done_o and no further AXI activity until a new start.

Verification
REQ-030 Directed test, clean memory: MEMORY_SIZE=32'h40, BASE_ADDR=32'h0, zero-wait RAM; pulse start_i.
- Required: 16 writes, data at word 3 = 32'hA5A5_5A59, then 16 reads.
- Required at the end: done_o=1, pass_o=1, err_cnt_o=0.
REQ-031 Directed test, stuck bit: the RAM model forces bit 0 = 0 at byte address 32'h14.
- Required: err_cnt_o=1, fail_addr_o=32'h0000_0014, pass_o=0.
REQ-032 Directed test, error responses: the slave returns b_resp=2'b10 on every write.
- Required: err_cnt_o=16 after the write phase, with fail_addr_o=32'h0.
REQ-033 Directed test, slow handshakes: aw_ready is delayed 3 cycles and w_ready 1 cycle.
- Required: valids held stable until their handshakes, exactly one b handshake per word, and test passes.
REQ-034 Directed test, reset and restart: drop rst_ni during read word 7, then restart.
- Required during reset: all outputs go to their reset values asynchronously.
- Required after restart: a fresh full test passes, and start_i pulses during busy_o have no effect.
